// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared definitions for the fetch datapath and its controller.
//   DATA_W / ADDR_W / PHASE_W : datapath, address and phase widths
//   HLT..JMP                  : 3-bit opcode constants carried in IR[7:5]
//   fsm_state_t               : RUN / HALTED state encoding of the phase FSM
package cpu_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned PHASE_W = 3;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } fsm_state_t;

  // Phase loaded on entry to HALTED.
  localparam logic [PHASE_W-1:0] HALT_PHASE = 3'd5;

endpackage

// File: rtl/phase_counter.sv
// phase_counter -- instruction phase counter with RUN/HALTED control FSM.
//   clk, rst (async, active high)
//   halt    : RUN -> HALTED, phase forced to 5
//   resume  : HALTED -> RUN, phase restarts at 0
//   stall   : in RUN at phase 1, hold phase (halt still wins)
//   phase   : current phase 0..7, wraps 7 -> 0
//   halted  : registered, high exactly while in HALTED
module phase_counter
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               resume,
  input  logic               stall,
  output logic [PHASE_W-1:0] phase,
  output logic               halted
);

  fsm_state_t state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      phase  <= '0;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt) begin
            state  <= ST_HALTED;
            phase  <= HALT_PHASE;
            halted <= 1'b1;
          end else if (!(stall && phase == 3'd1)) begin
            phase <= phase + 3'd1;
          end
        end
        ST_HALTED: begin
          if (resume) begin
            state  <= ST_RUN;
            phase  <= '0;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= ST_RUN;
          phase  <= '0;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- program counter, instruction register and address mux,
// sequenced by the phase_counter sub-module.
//   clk, rst (async, active high)
//   halt, resume          : FSM control from the controller
//   inc_pc, ld_pc, ld_ir  : PC/IR update strobes (ignored while halted)
//   sel                   : addr source, 1 = PC, 0 = IR operand
//   data_in [7:0]         : memory read data
//   mem_ready             : only when FETCH_STALL_EN is defined; low stalls phase 1
//   phase [2:0], opcode [2:0], addr [4:0], pc [4:0], halted
// Optional feature macro: FETCH_STALL_EN (memory-stall at phase 1).
module fetch_unit
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               halt,
  input  logic               inc_pc,
  input  logic               ld_pc,
  input  logic               ld_ir,
  input  logic               sel,
  input  logic               resume,
`ifdef FETCH_STALL_EN
  input  logic               mem_ready,
`endif
  input  logic [DATA_W-1:0]  data_in,
  output logic [PHASE_W-1:0] phase,
  output logic [2:0]         opcode,
  output logic [ADDR_W-1:0]  addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  logic [DATA_W-1:0] ir;
  logic              stall;

`ifdef FETCH_STALL_EN
  assign stall = ~mem_ready;
`else
  assign stall = 1'b0;
`endif

  phase_counter u_phase_counter (
    .clk    (clk),
    .rst    (rst),
    .halt   (halt),
    .resume (resume),
    .stall  (stall),
    .phase  (phase),
    .halted (halted)
  );

  // Gating on the registered halted flag lets the halting edge itself
  // still apply a coinciding increment or load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else if (!halted) begin
      if (ld_pc)
        pc <= ir[ADDR_W-1:0];
      else if (inc_pc)
        pc <= pc + 5'd1;
      if (ld_ir)
        ir <= data_in;
    end
  end

  assign addr   = sel ? pc : ir[ADDR_W-1:0];
  assign opcode = ir[7:5];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port halt  input  1  halt request from controller.
REQ-004 SHALL have port inc_pc  input  1  increment program counter.
REQ-005 SHALL have port ld_pc  input  1  load PC from IR operand field.
REQ-006 SHALL have port ld_ir  input  1  load IR from data_in.
REQ-007 SHALL have port sel  input  1  address select: 1 = PC, 0 = IR operand.
REQ-008 SHALL have port resume  input  1  single-cycle restart request out of HALTED.
REQ-009 SHALL have port data_in  input  8  memory read data.
REQ-010 SHALL have port phase  output  3  current instruction phase, 0..7, to controller.
REQ-011 SHALL have port opcode  output  3  IR[7:5], to controller.
REQ-012 SHALL have port addr  output  5  memory address.
REQ-013 SHALL have port pc  output  5  current program counter.
REQ-014 SHALL have port halted  output  1  high while in HALTED.

Function
REQ-015 SHALL implement a two-state FSM, RUN and HALTED; reset state is RUN.
REQ-016 In RUN, the phase counter SHALL advance by 1 each clock and wrap 7->0.
REQ-017 In RUN with halt=1 at an edge, the FSM SHALL go to HALTED and phase SHALL go to 5.
REQ-018 In HALTED, phase, PC and IR SHALL hold, and inc_pc, ld_pc and ld_ir SHALL be ignored.
REQ-019 In HALTED with resume=1 at an edge, the FSM SHALL go to RUN with phase=0; fetch restarts at the current PC.
REQ-020 resume in RUN SHALL be ignored; halt in HALTED SHALL be ignored.
REQ-021 PC: ld_pc=1 SHALL load IR[4:0]; otherwise inc_pc=1 SHALL load PC+1, wrapping 31->0; ld_pc has priority when both are high.
REQ-022 A halt edge that coincides with inc_pc SHALL still apply the increment (HLT phase 4).
REQ-023 IR SHALL load data_in on every edge with ld_ir=1; back-to-back loads (phases 2 and 3) are legal.
REQ-024 addr SHALL be combinational: sel ? pc : IR[4:0]; opcode SHALL equal IR[7:5] combinationally.
REQ-025 halted SHALL be a registered output, equal to 1 exactly when the FSM is in HALTED.

Reset
REQ-026 On rst=1, independent of clk: phase=0, PC=0, IR=8'h00, FSM=RUN, halted=0; addr therefore equals 0.
REQ-027 Reset mid-instruction SHALL abort it; the first edge after release SHALL give phase=1.

Configuration
REQ-028 The macro FETCH_STALL_EN SHALL control the memory-stall feature.
REQ-029 With FETCH_STALL_EN defined: add input mem_ready (1 bit); in RUN, at phase 1 with mem_ready=0, phase SHALL hold at 1; PC and IR are unaffected; halt still takes priority.
REQ-030 With FETCH_STALL_EN undefined: no mem_ready port exists and phase always advances per REQ-016.

Structure
REQ-031 Shared package cpu_pkg SHALL hold: opcode constants HLT..JMP (0..7), DATA_W=8, ADDR_W=5, PHASE_W=3, and the FSM state encoding.
REQ-032 The phase counter plus RUN/HALTED FSM SHALL be a sub-module phase_counter; PC, IR and the address mux stay in fetch_unit.

Verification
REQ-033 Release reset, idle inputs, 10 clocks -> phase sequence 1,2,3,4,5,6,7,0,1,2; pc=0; halted=0.
REQ-034 data_in=8'hE7 with ld_ir=1 at phases 2 and 3, then ld_pc=1 at phase 6 -> opcode=7, pc=5'd7; addr=7 when sel=0.
REQ-035 pc=31 with inc_pc=1 -> pc=0; inc_pc=1 and ld_pc=1 together with IR=8'h0A -> pc=10.
REQ-036 halt=1 and inc_pc=1 at phase 4 with pc=3 -> phase=5, halted=1, pc=4; 5 clocks with inc_pc/ld_ir pulsed -> no change; resume=1 -> phase=0, halted=0.
REQ-037 rst pulsed asynchronously mid-cycle at phase 6, pc=9 -> immediately phase=0, pc=0, IR=0.
REQ-038 With FETCH_STALL_EN: mem_ready=0 for 3 clocks at phase 1 -> phase stays 1 for 4 clocks total, then advances to 2.
